caph_rshift_actor: RTL and testbench
====================================

Name: caph_rshift_actor

Overview:
- Parametrised successor of the single-token right-shift actor in the CAPH/HCL dataflow library.
- Consumes data tokens on FIFO port in0 and shift-amount control tokens on FIFO port in1.
- Produces shifted tokens on FIFO port out0 through a one-entry registered output buffer.
- Supports logical or arithmetic shift, a sticky run-time shift amount and an optional mandatory configuration phase.

Parameters:
- WIDTH, 16, data token width in bits.
- SHIFT_W, 5, width of the shift-amount token; amounts 0..2^SHIFT_W-1.
- ARITH, 0, 0 = logical shift (zero fill), 1 = arithmetic shift (sign fill).
- DEFAULT_SHIFT, 1, shift amount loaded at reset.
- CFG_REQUIRED, 0, 1 = no data is consumed until at least one in1 token has been read.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in0_empty  in  1  data FIFO empty.
- in0  in  WIDTH  data FIFO head token.
- in0_rd  out  1  pop data FIFO.
- in1_empty  in  1  shift-amount FIFO empty.
- in1  in  SHIFT_W  shift-amount FIFO head token (unsigned).
- in1_rd  out  1  pop shift-amount FIFO.
- out0_full  in  1  output FIFO full.
- out0  out  WIDTH  output token.
- out0_wr  out  1  push output FIFO.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= CFG_REQUIRED ? WAIT_CFG : RUN.
  - amt <= DEFAULT_SHIFT.
  - buf_valid <= 0; out0 buffer data <= 0.
  - Reset mid-operation discards any buffered token. Inputs are not popped during reset.
- Outputs are combinational from registers and FIFO flags. All of in0_rd, in1_rd and out0_wr are 0 while reset==0.
- out0_wr = buf_valid & ~out0_full; out0 = buffer data at all times.
- Control read: in1_rd = ~in1_empty. On pop:
  - amt <= in1.
  - WAIT_CFG -> RUN.
  - in0_rd is forced to 0 in the same cycle, so control has priority over data.
- Data read: in0_rd = (state==RUN) & ~in1_rd & ~in0_empty & (~buf_valid | ~out0_full).
  - On pop, buffer data <= f(in0, amt) and buf_valid <= 1.
- Buffer drain: if out0_wr and no in0_rd in the same cycle, buf_valid <= 0.
  - Simultaneous drain and fill keeps buf_valid = 1, giving full throughput of 1 token/cycle.
- The new amt applies to the first data token popped in a later cycle. A data token popped in the same cycle as a control token cannot occur.
- Latency: data popped at edge N is presented on out0 with out0_wr in cycle N+1 if out0_full==0.
- Backpressure: while out0_full==1 the buffer holds its value and in0_rd = 0 whenever buf_valid = 1.
- State machine: WAIT_CFG -> RUN on the first in1 pop. RUN is terminal until reset. WAIT_CFG exists only when CFG_REQUIRED = 1.
- Shift function f(x,s), result is WIDTH bits:
  - ARITH = 0: x >> s; s >= WIDTH gives 0.
  - ARITH = 1: x >>> s; s >= WIDTH gives all bits equal to x[WIDTH-1].
  - s = 0 passes x unchanged.
- Empty/full edges: never pop an empty FIFO; never write while out0_full = 1. Input flags are sampled combinationally, with no cycle penalty.

Optional Feature:
- Macro: RSHIFT_ROUND_EN.
- Defined: round half-up.
  - result = f(x,s) + r, where r = bit (s-1) of x extended to infinite width (zero- or sign-extended per ARITH), and r = 0 when s == 0.
  - The sum is truncated to WIDTH bits; overflow is impossible for s >= 1.
  - The adder is combinational before the buffer, so latency is unchanged.
- Undefined: truncation only, identical to the Behaviour section. No extra logic is instantiated.

Test Plan:
1. Reset, then in1 empty, ARITH=0, DEFAULT_SHIFT=1; push in0 = 0x8001, 0x0004 with out0_full = 0 -> out0_wr pulses on consecutive cycles with 0x4000, 0x0002, each one cycle after its in0_rd.
2. ARITH=1: push in1 = 4, then in0 = 0xF000 -> in1_rd precedes in0_rd, out0 = 0xFF00. Then in1 = 20 -> the next in0 = 0x8000 gives 0xFFFF. With ARITH=0 the same inputs give 0x0F00 and 0x0000.
3. CFG_REQUIRED=1: data tokens waiting and in1 empty for 10 cycles -> in0_rd stays 0. Push in1 = 0 -> next cycle in0_rd = 1 and out0 = input unchanged.
4. Backpressure: out0_full held 1 for 5 cycles with 3 data tokens queued -> one token is buffered, in0_rd = 0 and out0_wr = 0 throughout. Release -> 3 tokens arrive in order at 1/cycle with no loss or duplication.
5. Reset asserted (reset = 0) for one edge while buf_valid = 1 and out0_full = 1 -> after release out0_wr = 0, the buffered token is lost and amt = DEFAULT_SHIFT.
6. RSHIFT_ROUND_EN, ARITH=1, s = 2: in0 = 0x0006 -> 0x0002; in0 = 0xFFFA (-6) -> 0xFFFF (-1); in0 = 0x0005 -> 0x0001. Without the macro the same inputs give 0x0001, 0xFFFE, 0x0001.

Source files
------------

// File: rtl/caph_rshift_actor.sv
// caph_rshift_actor: right-shifts data tokens from in0 by a sticky amount taken from in1 (logical or arithmetic).
// Latency: a token popped at edge N is offered on out0 with out0_wr in cycle N+1 through a one-entry buffer.
// Backpressure: out0_full holds the buffer and stalls in0; control tokens on in1 always win over data.
// Optional build macro RSHIFT_ROUND_EN adds round-half-up on the shifted result.
module caph_rshift_actor #(
  parameter int WIDTH         = 16,
  parameter int SHIFT_W       = 5,
  parameter int ARITH         = 0,
  parameter int DEFAULT_SHIFT = 1,
  parameter int CFG_REQUIRED  = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in0_empty,
  input  logic [WIDTH-1:0]   in0,
  output logic               in0_rd,
  input  logic               in1_empty,
  input  logic [SHIFT_W-1:0] in1,
  output logic               in1_rd,
  input  logic               out0_full,
  output logic [WIDTH-1:0]   out0,
  output logic               out0_wr
);

  typedef enum logic {
    ST_WAIT_CFG = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  state_t             r_state;
  logic [SHIFT_W-1:0] r_amt;
  logic               r_buf_vld;
  logic [WIDTH-1:0]   r_buf_dat;

  logic               w_in0_rd;
  logic               w_in1_rd;
  logic               w_out0_wr;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_result;

  // Handshakes: control pops whenever available and blocks data in that cycle;
  // data pops only when the buffer is free or draining this cycle.
  assign w_in1_rd  = reset & ~in1_empty;
  assign w_out0_wr = reset & r_buf_vld & ~out0_full;
  assign w_in0_rd  = reset & (r_state == ST_RUN) & ~w_in1_rd & ~in0_empty
                   & (~r_buf_vld | ~out0_full);

`ifdef RSHIFT_ROUND_EN
  logic [SHIFT_W-1:0] w_amt_m1;
  logic               w_rbit_raw;
  logic               w_rbit;

  // Round bit is bit (s-1) of the extended input, i.e. the LSB of x shifted by s-1.
  assign w_amt_m1 = r_amt - SHIFT_W'(1);
`endif

  // Shift core; shift amounts beyond WIDTH naturally saturate to zero / sign fill.
  generate
    if (ARITH != 0) begin : g_arith
      logic signed [WIDTH-1:0] w_in0_s;
      assign w_in0_s   = in0;
      assign w_shifted = w_in0_s >>> r_amt;
`ifdef RSHIFT_ROUND_EN
      assign w_rbit_raw = 1'(w_in0_s >>> w_amt_m1);
`endif
    end else begin : g_logic
      assign w_shifted = in0 >> r_amt;
`ifdef RSHIFT_ROUND_EN
      assign w_rbit_raw = 1'(in0 >> w_amt_m1);
`endif
    end
  endgenerate

`ifdef RSHIFT_ROUND_EN
  // Round half-up: add the first discarded bit; a zero shift discards nothing.
  assign w_rbit   = (r_amt != '0) & w_rbit_raw;
  assign w_result = w_shifted + {{(WIDTH-1){1'b0}}, w_rbit};
`else
  assign w_result = w_shifted;
`endif

  // State, sticky shift amount and the one-entry output buffer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= (CFG_REQUIRED != 0) ? ST_WAIT_CFG : ST_RUN;
      r_amt     <= SHIFT_W'(DEFAULT_SHIFT);
      r_buf_vld <= 1'b0;
      r_buf_dat <= '0;
    end else begin
      if (w_in1_rd) begin
        r_amt   <= in1;
        r_state <= ST_RUN;
      end
      if (w_in0_rd) begin
        r_buf_dat <= w_result;
        r_buf_vld <= 1'b1;
      end else if (w_out0_wr) begin
        r_buf_vld <= 1'b0;
      end
    end
  end

  assign in0_rd  = w_in0_rd;
  assign in1_rd  = w_in1_rd;
  assign out0_wr = w_out0_wr;
  assign out0    = r_buf_dat;

endmodule

// File: tb/tb_caph_rshift_actor.sv
// Bench for caph_rshift_actor: dut0 logical/no-config, dut1 arithmetic/config-required.
// FIFO models feed both DUTs; expected tokens are queued at push time from an arithmetic model.
// A negedge monitor pops the expected queues whenever out0_wr is seen.
module tb_caph_rshift_actor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  in0_empty, in1_empty, out0_full, in0_rd, in1_rd, out0_wr;
  logic [15:0] in0  [2];
  logic [4:0]  in1  [2];
  logic [15:0] out0 [2];

  logic [15:0] d_mem [2][256];
  logic [4:0]  c_mem [2][64];
  logic [15:0] e_mem [2][256];
  int d_wp [2];
  int d_rp [2];
  int c_wp [2];
  int c_rp [2];
  int e_wp [2];
  int e_rp [2];
  int m_amt [2];
  int wr_cnt [2];
  logic [1:0] s_in0_rd = '0;
  logic [1:0] s_in1_rd = '0;
  logic [1:0] prev_rd  = '0;
  int checks = 0;
  int errors = 0;

  caph_rshift_actor #(.WIDTH(16), .SHIFT_W(5), .ARITH(0), .DEFAULT_SHIFT(1), .CFG_REQUIRED(0)) u_dut0 (
    .clock(clk), .reset(reset),
    .in0_empty(in0_empty[0]), .in0(in0[0]), .in0_rd(in0_rd[0]),
    .in1_empty(in1_empty[0]), .in1(in1[0]), .in1_rd(in1_rd[0]),
    .out0_full(out0_full[0]), .out0(out0[0]), .out0_wr(out0_wr[0])
  );

  caph_rshift_actor #(.WIDTH(16), .SHIFT_W(5), .ARITH(1), .DEFAULT_SHIFT(3), .CFG_REQUIRED(1)) u_dut1 (
    .clock(clk), .reset(reset),
    .in0_empty(in0_empty[1]), .in0(in0[1]), .in0_rd(in0_rd[1]),
    .in1_empty(in1_empty[1]), .in1(in1[1]), .in1_rd(in1_rd[1]),
    .out0_full(out0_full[1]), .out0(out0[1]), .out0_wr(out0_wr[1])
  );

  // Reference: divide by 2^s with floor (what a right shift means numerically),
  // optionally adding half an LSB first for round-half-up.
  function automatic logic [15:0] f_model(input logic [15:0] x, input int s, input bit arith);
    longint v, d, q;
    if (arith) v = longint'($signed(x));
    else       v = longint'(x);
    d = longint'(1) << s;
`ifdef RSHIFT_ROUND_EN
    if (s > 0) v = v + (d / 2);
`endif
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q[15:0];
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, exp);
    end
  endtask

  function automatic bit drained();
    bit ok = 1'b1;
    for (int i = 0; i < 2; i++)
      if (d_wp[i] != d_rp[i] || c_wp[i] != c_rp[i] || e_wp[i] != e_rp[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic update_inputs();
    for (int i = 0; i < 2; i++) begin
      in0_empty[i] = (d_wp[i] == d_rp[i]);
      in0[i]       = d_mem[i][d_rp[i] & 255];
      in1_empty[i] = (c_wp[i] == c_rp[i]);
      in1[i]       = c_mem[i][c_rp[i] & 63];
    end
  endtask

  task automatic push_data(input int i, input logic [15:0] x, input int s);
    d_mem[i][d_wp[i] & 255] = x;
    d_wp[i]++;
    e_mem[i][e_wp[i] & 255] = f_model(x, s, (i == 1));
    e_wp[i]++;
    update_inputs();
  endtask

  task automatic push_ctl(input int i, input int c);
    c_mem[i][c_wp[i] & 63] = 5'(c);
    c_wp[i]++;
    m_amt[i] = c;
    update_inputs();
  endtask

  // One clock: pops sampled at the preceding negedge are applied after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_in0_rd[i]) d_rp[i]++;
      if (s_in1_rd[i]) c_rp[i]++;
    end
    update_inputs();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    out0_full = '0;
    while (!drained() && n < 300) begin
      tick();
      n++;
    end
    chk(name, 0, 32'(drained()), 32'd1);
  endtask

  function automatic logic [15:0] rand_tok();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: protocol rules, one-cycle latency, and scoreboard comparison.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      s_in0_rd[i] = in0_rd[i];
      s_in1_rd[i] = in1_rd[i];
      if (!reset) begin
        chk("reset_quiet", i, {29'd0, in0_rd[i], in1_rd[i], out0_wr[i]}, 32'd0);
      end else begin
        chk("protocol", i, {28'd0, in0_rd[i] & in0_empty[i], in1_rd[i] & in1_empty[i],
                            out0_wr[i] & out0_full[i], in0_rd[i] & in1_rd[i]}, 32'd0);
        if (prev_rd[i] && !out0_full[i]) chk("latency", i, 32'(out0_wr[i]), 32'd1);
        if (out0_wr[i]) begin
          wr_cnt[i]++;
          if (e_rp[i] == e_wp[i]) begin
            checks++;
            errors++;
            $display("FAIL extra_output dut%0d: got %0h expected no write", i, out0[i]);
          end else begin
            chk("data", i, 32'(out0[i]), 32'(e_mem[i][e_rp[i] & 255]));
            e_rp[i]++;
          end
        end
      end
      prev_rd[i] = in0_rd[i] & reset;
    end
  end

  initial begin
    int pops [2];
    int wbase [2];
    logic [15:0] x;
    int c;

    reset     = 1'b0;
    out0_full = '0;
    m_amt[0]  = 1;
    m_amt[1]  = 3;
    update_inputs();

    // dut0 uses the reset amount 1; dut1 will be configured with 0 before any data moves.
    push_data(0, 16'h8001, 1);
    push_data(0, 16'h0004, 1);
    push_data(1, 16'h8001, 0);
    push_data(1, 16'h0004, 0);
    repeat (3) tick();

    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out0_wr", i, 32'(out0_wr[i]), 32'd0);
      chk("rst_out0", i, 32'(out0[i]), 32'd0);
    end
    chk("first_pop", 0, 32'(in0_rd[0]), 32'd1);
    chk("cfg_block", 1, 32'(in0_rd[1]), 32'd0);

    repeat (10) begin
      tick();
      chk("cfg_wait", 1, 32'(s_in0_rd[1]), 32'd0);
    end

    push_ctl(1, 0);
    #1;
    chk("ctl_first", 1, {30'd0, in1_rd[1], in0_rd[1]}, 32'd2);
    tick();
    #1;
    chk("data_after_ctl", 1, 32'(in0_rd[1]), 32'd1);
    wait_drain("drain_t1");

    // Control and data pushed together: control must be consumed first.
    for (int i = 0; i < 2; i++) begin
      push_ctl(i, 4);
      push_data(i, 16'hF000, m_amt[i]);
    end
    wait_drain("drain_t2a");
    for (int i = 0; i < 2; i++) begin
      push_ctl(i, 20);
      push_data(i, 16'h8000, m_amt[i]);
    end
    wait_drain("drain_t2b");

    // Backpressure: exactly one token enters the buffer, then a full-rate burst.
    out0_full = 2'b11;
    for (int i = 0; i < 2; i++) begin
      pops[i] = 0;
      for (int k = 0; k < 3; k++) push_data(i, rand_tok(), m_amt[i]);
    end
    repeat (5) begin
      tick();
      for (int i = 0; i < 2; i++) pops[i] += 32'(s_in0_rd[i]);
    end
    for (int i = 0; i < 2; i++) begin
      chk("bp_pops", i, pops[i], 32'd1);
      wbase[i] = wr_cnt[i];
    end
    out0_full = '0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) chk("bp_burst", i, wr_cnt[i] - wbase[i], 32'd3);
    wait_drain("drain_t4");

    // Reset while a token is held under backpressure: token lost, amount back to default.
    for (int i = 0; i < 2; i++) push_ctl(i, 7);
    wait_drain("drain_t5a");
    out0_full = 2'b11;
    for (int i = 0; i < 2; i++) push_data(i, 16'h1234, m_amt[i]);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) e_wp[i]--;
    reset     = 1'b1;
    m_amt[0]  = 1;
    out0_full = '0;
    #1;
    for (int i = 0; i < 2; i++) chk("rst_drop", i, 32'(out0_wr[i]), 32'd0);
    repeat (2) tick();
    x = rand_tok();
    push_data(0, x, m_amt[0]);
    push_data(1, x, 9);
    repeat (3) tick();
    chk("cfg_after_rst", 1, d_wp[1] - d_rp[1], 32'd1);
    push_ctl(1, 9);
    wait_drain("drain_t5b");

    // Random phases with random per-DUT backpressure.
    for (int p = 0; p < 40; p++) begin
      int rem;
      int n;
      if ($urandom_range(0, 1) == 1) begin
        c = int'($urandom_range(0, 31));
        for (int i = 0; i < 2; i++) push_ctl(i, c);
      end
      rem = int'($urandom_range(1, 8));
      n   = 0;
      while ((rem > 0 || !drained()) && n < 400) begin
        if (rem > 0 && $urandom_range(0, 2) != 0) begin
          x = rand_tok();
          for (int i = 0; i < 2; i++) push_data(i, x, m_amt[i]);
          rem--;
        end
        out0_full[0] = ($urandom_range(0, 3) == 0);
        out0_full[1] = ($urandom_range(0, 3) == 0);
        tick();
        n++;
      end
      chk("phase_done", 0, 32'(rem == 0 && drained()), 32'd1);
    end

    wait_drain("drain_end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
